// File: rtl/data_mem_responder_pkg.sv
// Shared types and encodings for the load/store memory responder.
// Imported by the responder top and its lane-alignment helper.
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StWait   = 2'b01,
      StAccess = 2'b10,
      StResp   = 2'b11
   } state_e;

   localparam logic [1:0] SizeB = 2'b00;
   localparam logic [1:0] SizeH = 2'b01;
   localparam logic [1:0] SizeW = 2'b10;

   // Request fields captured at the accept edge; the address is held separately
   // because its stored width depends on the array depth.
   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        is_unsigned;
      logic [31:0] wdata;
   } req_t;

   function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
      logic e;
      case (size)
         SizeB:   e = 1'b0;
         SizeH:   e = addr_lo[0];
         SizeW:   e = |addr_lo;
         default: e = 1'b1;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Combinational byte-lane steering: store byte-enables and replicated data,
// load lane selection with sign/zero extension, and the alignment error flag.
module data_mem_responder_mem_lane_align
   import data_mem_responder_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext,
   output logic        err
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign err   = access_err(size, addr_lo);
   assign rbyte = rword[{addr_lo, 3'b000} +: 8];
   assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

   // Errored accesses produce no enables and zero load data.
   always_comb begin
      be        = 4'b0000;
      wdata_rep = wdata;
      rdata_ext = '0;
      if (!err) begin
         case (size)
            SizeB: begin
               be        = 4'b0001 << addr_lo;
               wdata_rep = {4{wdata[7:0]}};
               rdata_ext = {{24{rbyte[7] & ~is_unsigned}}, rbyte};
            end
            SizeH: begin
               be        = addr_lo[1] ? 4'b1100 : 4'b0011;
               wdata_rep = {2{wdata[15:0]}};
               rdata_ext = {{16{rhalf[15] & ~is_unsigned}}, rhalf};
            end
            SizeW: begin
               be        = 4'b1111;
               rdata_ext = rword;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Multicycle data-memory responder: one request at a time, programmable wait,
// access on an internal word array, response held until accepted.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 2,
   parameter int unsigned LAT_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned OFF_W = IDX_W + 2;

   state_e           state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   req_t             req_q;
   logic [OFF_W-1:0] addr_q;
   logic [31:0]      mem [DEPTH];

   logic             accept;
   logic [IDX_W-1:0] idx;
   logic [31:0]      rword;
   logic [3:0]       be;
   logic [31:0]      wdata_rep;
   logic [31:0]      rdata_ext;
   logic             err;
   logic             unused_addr;

   // Addresses wrap modulo the array size; upper bits are deliberately dropped.
   assign unused_addr = ^req_addr[ADDR_W-1:OFF_W];

   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);
   assign accept    = req_valid && req_ready;
   assign idx       = addr_q[OFF_W-1:2];
   assign rword     = mem[idx];

   data_mem_responder_mem_lane_align u_lane_align (
      .addr_lo     (addr_q[1:0]),
      .size        (req_q.size),
      .is_unsigned (req_q.is_unsigned),
      .wdata       (req_q.wdata),
      .rword       (rword),
      .be          (be),
      .wdata_rep   (wdata_rep),
      .rdata_ext   (rdata_ext),
      .err         (err)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               if (LATENCY == 0) begin
                  state_d = StAccess;
               end else begin
                  cnt_d   = LAT_W'(LATENCY);
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - LAT_W'(1);
            if (cnt_q == LAT_W'(1)) state_d = StAccess;
         end
         StAccess: state_d = StResp;
         StResp:   if (rsp_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Reset also drops any latched-but-uncommitted store.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         req_q     <= '0;
         addr_q    <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            req_q.we          <= req_we;
            req_q.size        <= req_size;
            req_q.is_unsigned <= req_unsigned;
            req_q.wdata       <= req_wdata;
            addr_q            <= req_addr[OFF_W-1:0];
         end
         if (state_q == StAccess) begin
            rsp_rdata <= req_q.we ? 32'h0 : rdata_ext;
            rsp_err   <= err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == StAccess && req_q.we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expectations are queued per request
// and popped when the response appears.
module tb_data_mem_responder;

   localparam int unsigned LAT = 2;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   data_mem_responder #(
      .ADDR_W  (32),
      .DEPTH   (64),
      .LATENCY (LAT),
      .LAT_W   (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request, scrambles the inputs after acceptance, and reports the
   // response and the number of cycles from the accept cycle to rsp_valid.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er, output int lat,
                         output bit to);
      int n;
      to  = 1'b0;
      rd  = '0;
      er  = 1'b0;
      lat = -1;
      @(posedge clk); #1;
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         to        = 1'b1;
         req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid    = 1'b0;
      req_we       = ~we;
      req_size     = 2'($urandom_range(0, 3));
      req_unsigned = ~uns;
      req_addr     = $urandom;
      req_wdata    = $urandom;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 50);
      if (!rsp_valid) begin
         to = 1'b1;
         return;
      end
      lat = n;
      rd  = rsp_rdata;
      er  = rsp_err;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst          = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      rsp_ready    = 1'b1;
      #1;
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b rdata=%h err=%b want 1 0 00000000 0",
                  req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
      end
   endtask

   // Runs a table of requests, checking data, error flag and latency.
   task automatic run_table(input logic we[], input logic [1:0] sz[], input logic un[],
                            input logic [31:0] ad[], input logic [31:0] wd[],
                            input logic [31:0] er_d[], input logic er_e[], input string nm[]);
      logic [31:0] rd;
      logic        er;
      int          lat;
      bit          to;
      exp_t        e;
      for (int i = 0; i < nm.size(); i++) begin
         sb.push_back('{rdata: er_d[i], err: er_e[i], name: nm[i]});
         do_req(we[i], sz[i], un[i], ad[i], wd[i], rd, er, lat, to);
         e = sb.pop_front();
         n_cmp++;
         if (to) begin
            n_fail++;
            $display("FAIL %s_timeout: got no response want response within 50 cycles", e.name);
            continue;
         end
         if (rd !== e.rdata) begin
            n_fail++;
            $display("FAIL %s_rdata: got %h want %h", e.name, rd, e.rdata);
         end
         n_cmp++;
         if (er !== e.err) begin
            n_fail++;
            $display("FAIL %s_err: got %b want %b", e.name, er, e.err);
         end
         n_cmp++;
         if (lat != int'(LAT) + 2) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d want %0d", e.name, lat, LAT + 2);
         end
      end
   endtask

   task automatic test_word_store_load();
      run_table('{1'b1, 1'b0}, '{2'b10, 2'b10}, '{1'b0, 1'b0}, '{32'h10, 32'h10},
                '{32'hDEADBEEF, 32'h0}, '{32'h0, 32'hDEADBEEF}, '{1'b0, 1'b0},
                '{"sw_10", "lw_10"});
   endtask

   task automatic test_subword_loads();
      run_table('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00},
                '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1},
                '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10, 32'h11},
                '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF, 32'hFFFFFFEF,
                  32'h000000BE},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                '{"lb_13", "lbu_13", "lh_12", "lhu_10", "lb_10", "lbu_11"});
   endtask

   task automatic test_subword_stores();
      run_table('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
                '{2'b10, 2'b00, 2'b10, 2'b01, 2'b10},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                '{32'h20, 32'h21, 32'h20, 32'h22, 32'h20},
                '{32'h11223344, 32'hFFFFFFAA, 32'h0, 32'h77775566, 32'h0},
                '{32'h0, 32'h0, 32'h1122AA44, 32'h0, 32'h5566AA44},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                '{"sw_20", "sb_21", "lw_20_after_sb", "sh_22", "lw_20_after_sh"});
   endtask

   task automatic test_errors();
      run_table('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
                '{2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                '{32'h21, 32'h20, 32'h22, 32'h20, 32'h20, 32'h20},
                '{32'hBBBBBBBB, 32'h0, 32'h0, 32'h0, 32'h99999999, 32'h0},
                '{32'h0, 32'h5566AA44, 32'h0, 32'h0, 32'h0, 32'h5566AA44},
                '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
                '{"sh_21_misaligned", "lw_20_unchanged", "lw_22_misaligned", "ld_size11",
                  "st_size11", "lw_20_still_unchanged"});
   endtask

   task automatic test_backpressure();
      logic [31:0] rd;
      logic        er;
      int          lat;
      bit          to;
      exp_t        e;
      rsp_ready = 1'b0;
      sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, name: "bp_lw_10"});
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat, to);
      e = sb.pop_front();
      n_cmp++;
      if (to || rd !== e.rdata || er !== e.err) begin
         n_fail++;
         $display("FAIL %s: got to=%b rdata=%h err=%b want 0 %h %b", e.name, to, rd, er,
                  e.rdata, e.err);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: got vld=%b rdata=%h rdy=%b want 1 %h 0", i, rsp_valid,
                     rsp_rdata, req_ready, e.rdata);
         end
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_pending: got vld=%b want 1", rsp_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_released: got rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_reset_mid_store();
      int n;
      run_table('{1'b1, 1'b0}, '{2'b10, 2'b10}, '{1'b0, 1'b0}, '{32'h30, 32'h10},
                '{32'h0, 32'h0}, '{32'h0, 32'hDEADBEEF}, '{1'b0, 1'b0},
                '{"sw_30_zero", "lw_10_prime"});
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b10;
      req_addr  = 32'h30;
      req_wdata = 32'h12345678;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_in_wait: got rdy=%b vld=%b want 0 0", req_ready, rsp_valid);
      end
      #1 rst = 1'b0;
      #1;
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_outputs: got rdy=%b vld=%b rdata=%h err=%b want 1 0 00000000 0",
                  req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      run_table('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
                '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                '{32'h30, 32'h104, 32'h04, 32'h04, 32'h104},
                '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0BADC0DE, 32'h0},
                '{32'h0, 32'h0, 32'hCAFEF00D, 32'h0, 32'h0BADC0DE},
                '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
                '{"lw_30_discarded", "sw_104", "lw_04_alias", "sw_04", "lw_104_alias"});
   endtask

   initial begin
      test_reset();
      test_word_store_load();
      test_subword_loads();
      test_subword_stores();
      test_errors();
      test_backpressure();
      test_reset_mid_store();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish before 200000");
      $fatal(1);
   end

endmodule
